// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - runtime-programmable clock-divider bank; optional sync restart under CLKDIV_SYNC_EN
module clk_div_bank #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 255
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [2:0]        rd_ch,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [CNT_W-1:0]  rd_div,
    output logic [NUM_CH-1:0] clk,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

    // Restart request common to all channels; tied off when the sync feature is absent.
    logic sync_req;
`ifdef CLKDIV_SYNC_EN
    assign sync_req = sync;
`else
    assign sync_req = 1'b0;
`endif

    // Active divide values of all channels, flattened for the readback mux.
    logic [NUM_CH*CNT_W-1:0] act_flat;
    logic [CNT_W-1:0]        rd_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_pend;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             wr_hit;
        logic             term;

        // Channel indices never exceed 7, so an out-of-range wr_ch simply matches nothing.
        assign wr_hit = wr_en && (wr_ch == 3'(i));
        assign term   = (cnt == div_act);

        // Per-channel divider: count to div_act, toggle, and swap in a pending value only at a boundary.
        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt      <= '0;
                div_act  <= DEF_VAL;
                div_pend <= DEF_VAL;
                pend     <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (sync_req || !ch_en[i]) begin
                // Idle or restarting: output parked low, counter at zero, so a new value can land now.
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend   <= 1'b0;
                if (wr_hit) begin
                    div_act  <= wr_div;
                    div_pend <= wr_div;
                end else if (pend) begin
                    div_act <= div_pend;
                end
            end else begin
                if (term) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= ~clk_q;
                    if (pend) begin
                        div_act <= div_pend;
                        pend    <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end
                // A write landing on the boundary cycle waits for the following boundary.
                if (wr_hit) begin
                    div_pend <= wr_div;
                    pend     <= 1'b1;
                end
            end
        end

        assign clk[i]                      = clk_q;
        assign tick[i]                     = tick_q;
        assign act_flat[i*CNT_W +: CNT_W]  = div_act;
    end

    // Readback select; unmatched channel numbers read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_sel = act_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    // Registered readback of the active divide value.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rd_div <= DEF_VAL;
        end else begin
            rd_div <= rd_sel;
        end
    end

endmodule
